// File: rtl/net_pkg.sv
// Shared net link types: beat width, timestamp width and the buffered entry layout.
package net_pkg;

   localparam int NET_DATA_W = 584;
   localparam int NET_TS_W   = 16;
   localparam int NET_DEPTH  = 16;
   localparam int NET_CNT_W  = 32;

   typedef logic [NET_DATA_W-1:0] net_beat_t;

   // One buffered beat plus the cycle stamp at which it may leave the link.
   typedef struct packed {
      net_beat_t             data;
      logic [NET_TS_W-1:0]   rel;
   } link_entry_t;

endpackage

// File: rtl/net_link_fifo.sv
// Synchronous FIFO holding link entries as flat vectors; wrap-bit pointers and registered count.
module net_link_fifo #(
   parameter int W     = 600,
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic                       pop,
   input  logic [W-1:0]               wr_data,
   output logic [W-1:0]               rd_data,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic          full;
   logic          push_ok;
   logic          pop_ok;

   assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
   assign empty   = (wr_ptr == rd_ptr);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign rd_data = mem[rd_ptr[AW-1:0]];

   // Storage array is not reset; the top masks the head payload while empty.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr[AW-1:0]] <= wr_data;
      end
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/net_link_delay.sv
// Inter-node link model: in-order beat buffer releasing each beat after a per-beat latency.
module net_link_delay
   import net_pkg::*;
#(
   parameter int DATA_W = NET_DATA_W,
   parameter int DEPTH  = NET_DEPTH,
   parameter int TS_W   = NET_TS_W,
   parameter int CNT_W  = NET_CNT_W
) (
   input  logic                       io_ap_clk,
   input  logic                       io_ap_rst_n,
   input  logic                       io_in_valid,
   output logic                       io_in_ready,
   input  logic [DATA_W-1:0]          io_in_bits_data,
   output logic                       io_out_valid,
   input  logic                       io_out_ready,
   output logic [DATA_W-1:0]          io_out_bits_data,
   input  logic [TS_W-2:0]            io_cfg_latency,
   input  logic                       io_stall,
   output logic [$clog2(DEPTH):0]     io_occupancy,
   output logic [CNT_W-1:0]           io_count_in,
   output logic [CNT_W-1:0]           io_count_out
);

   localparam int AW = $clog2(DEPTH);
   localparam int EW = DATA_W + TS_W;

   logic [TS_W-1:0]    now;
   logic [TS_W-1:0]    ingress_rel;
   logic [TS_W-1:0]    head_rel;
   logic [TS_W-1:0]    age;
   logic [DATA_W-1:0]  head_data;
   logic [EW-1:0]      wr_entry;
   logic [EW-1:0]      rd_entry;
   logic               fifo_empty;
   logic               head_eligible;
   logic               in_ready_q;
   logic               push;
   logic               pop;
   logic [AW:0]        occ;
   logic [AW:0]        occ_next;
   logic [CNT_W-1:0]   cnt_in;
   logic [CNT_W-1:0]   cnt_out;

   assign push        = io_in_valid && in_ready_q;
   assign ingress_rel = now + TS_W'(io_cfg_latency);
   assign wr_entry    = {io_in_bits_data, ingress_rel};
   assign {head_data, head_rel} = rd_entry;

   // Signed age test: the head may leave once now has caught up with its release stamp.
   assign age           = now - head_rel;
   assign head_eligible = !age[TS_W-1];

   assign io_out_valid     = !fifo_empty && head_eligible && !io_stall;
   assign pop              = io_out_valid && io_out_ready;
   assign io_out_bits_data = fifo_empty ? '0 : head_data;

   assign io_in_ready  = in_ready_q;
   assign io_occupancy = occ;
   assign io_count_in  = cnt_in;
   assign io_count_out = cnt_out;

   net_link_fifo #(
      .W     (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (io_ap_clk),
      .rst_n   (io_ap_rst_n),
      .push    (push),
      .pop     (pop),
      .wr_data (wr_entry),
      .rd_data (rd_entry),
      .empty   (fifo_empty),
      .count   (occ)
   );

   // Occupancy after this cycle's transfers, used to register the ingress ready.
   always_comb begin
      occ_next = occ;
      case ({push, pop})
         2'b10:   occ_next = occ + 1'b1;
         2'b01:   occ_next = occ - 1'b1;
         default: occ_next = occ;
      endcase
   end

   // Ready is a flop so the tx side never sees a path from io_out_ready.
   always_ff @(posedge io_ap_clk or negedge io_ap_rst_n) begin
      if (!io_ap_rst_n) begin
         in_ready_q <= 1'b0;
      end else begin
         in_ready_q <= (occ_next != (AW+1)'(DEPTH));
      end
   end

   // Free-running timestamp that wraps naturally.
   always_ff @(posedge io_ap_clk or negedge io_ap_rst_n) begin
      if (!io_ap_rst_n) begin
         now <= '0;
      end else begin
         now <= now + 1'b1;
      end
   end

   // Accepted and delivered beat counters, wrapping silently.
   always_ff @(posedge io_ap_clk or negedge io_ap_rst_n) begin
      if (!io_ap_rst_n) begin
         cnt_in  <= '0;
         cnt_out <= '0;
      end else begin
         if (push) begin
            cnt_in <= cnt_in + 1'b1;
         end
         if (pop) begin
            cnt_out <= cnt_out + 1'b1;
         end
      end
   end

endmodule
